// File: rtl/gray_win_pkg.sv
// Shared types, default widths and the coordinate helper for the 3x3 window generator.
package gray_win_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_X_W    = 10;

    typedef logic [DEF_DATA_W-1:0] pixel_t;
    typedef pixel_t window_t [3][3];

    // Decrement with wrap: 0 maps to max, anything else to x-1.
    function automatic int unsigned wrap_dec(input int unsigned x, input int unsigned max);
        return (x == 0) ? max : x - 1;
    endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// Enable-gated delay line: oQ shows the sample written exactly DEPTH enabled cycles ago.
// Read is combinational from the slot about to be overwritten (read-before-write).
module gray_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEN,
    input  logic [DATA_W-1:0] iD,
    output logic [DATA_W-1:0] oQ
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     addr;

    assign oQ = mem[addr];

    // Circular pointer; advances only on enabled cycles so gaps insert no bubbles.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            addr <= '0;
        end else if (iEN) begin
            addr <= (addr == LAST) ? '0 : addr + AW'(1);
        end
    end

    // Storage is deliberately not reset; downstream border masking hides stale lines.
    always_ff @(posedge iCLK) begin
        if (iEN) begin
            mem[addr] <= iD;
        end
    end

endmodule

// File: rtl/gray_window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift window,
// registered with valid, border mask and centre coordinates.
module gray_window3x3
    import gray_win_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int X_W        = DEF_X_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iGray,
    output logic [DATA_W-1:0] o00,
    output logic [DATA_W-1:0] o01,
    output logic [DATA_W-1:0] o02,
    output logic [DATA_W-1:0] o10,
    output logic [DATA_W-1:0] o11,
    output logic [DATA_W-1:0] o12,
    output logic [DATA_W-1:0] o20,
    output logic [DATA_W-1:0] o21,
    output logic [DATA_W-1:0] o22,
    output logic              oDVAL,
    output logic              oBorder,
    output logic [X_W-1:0]    oX,
    output logic [X_W-1:0]    oY
);

    localparam logic [X_W-1:0] COL_MAX = X_W'(IMG_WIDTH - 1);
    localparam logic [X_W-1:0] ROW_MAX = X_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0]    col, row;
    logic [X_W-1:0]    c_eff, r_eff;
    logic              border_next;
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic [DATA_W-1:0] win [3][3];
    logic              dval_q, border_q;
    logic [X_W-1:0]    x_q, y_q;

    // Coordinates of the pixel being accepted; SOF forces (0,0) ahead of any wrap.
    always_comb begin
        c_eff       = iSOF ? '0 : col;
        r_eff       = iSOF ? '0 : row;
        border_next = (r_eff < X_W'(2)) || (c_eff < X_W'(2));
    end

    // Raster counters, advanced once per accepted pixel.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            col <= '0;
            row <= '0;
        end else if (iDVAL) begin
            if (c_eff == COL_MAX) begin
                col <= '0;
                row <= (r_eff == ROW_MAX) ? '0 : r_eff + X_W'(1);
            end else begin
                col <= c_eff + X_W'(1);
                row <= r_eff;
            end
        end
    end

    gray_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb0 (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (iDVAL),
        .iD     (iGray),
        .oQ     (lb0_q)
    );

    gray_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iEN    (iDVAL),
        .iD     (lb0_q),
        .oQ     (lb1_q)
    );

    // Window shift: each row moves left, newest column enters at index 2.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (iDVAL) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1_q;
            win[1][2] <= lb0_q;
            win[2][2] <= iGray;
        end
    end

    // Output qualifiers: valid every cycle, border and centre only on accepted pixels.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dval_q   <= 1'b0;
            border_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            dval_q <= iDVAL;
            if (iDVAL) begin
                border_q <= border_next;
                x_q      <= X_W'(wrap_dec(32'(c_eff), 32'(COL_MAX)));
                y_q      <= X_W'(wrap_dec(32'(r_eff), 32'(ROW_MAX)));
            end
        end
    end

    assign oDVAL   = dval_q;
    assign oBorder = border_q;
    assign oX      = x_q;
    assign oY      = y_q;

    assign o00 = border_q ? '0 : win[0][0];
    assign o01 = border_q ? '0 : win[0][1];
    assign o02 = border_q ? '0 : win[0][2];
    assign o10 = border_q ? '0 : win[1][0];
    assign o11 = border_q ? '0 : win[1][1];
    assign o12 = border_q ? '0 : win[1][2];
    assign o20 = border_q ? '0 : win[2][0];
    assign o21 = border_q ? '0 : win[2][1];
    assign o22 = border_q ? '0 : win[2][2];

endmodule

// File: tb/tb_gray_window3x3.sv
// Directed bench for gray_window3x3 on a 4x4 image, pixel value = offset + 16*r + c.
module tb_gray_window3x3;
    import gray_win_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk;
    logic        rst_n;
    logic        dval_in;
    logic        sof_in;
    pixel_t      gray_in;
    pixel_t      t00, t01, t02, t10, t11, t12, t20, t21, t22;
    logic        dval_out;
    logic        border_out;
    logic [9:0]  x_out, y_out;

    int          total;
    int          bad;
    int          unmasked;
    pixel_t      exp_taps [9];
    pixel_t      hand22 [9];

    gray_window3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8), .X_W(10)) dut (
        .iCLK    (clk),
        .iRST_N  (rst_n),
        .iDVAL   (dval_in),
        .iSOF    (sof_in),
        .iGray   (gray_in),
        .o00     (t00),
        .o01     (t01),
        .o02     (t02),
        .o10     (t10),
        .o11     (t11),
        .o12     (t12),
        .o20     (t20),
        .o21     (t21),
        .o22     (t22),
        .oDVAL   (dval_out),
        .oBorder (border_out),
        .oX      (x_out),
        .oY      (y_out)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        pixel_t obs [9];
        obs = '{t00, t01, t02, t10, t11, t12, t20, t21, t22};
        for (int k = 0; k < 9; k++) chk($sformatf("%s_tap%0d", tag, k), 32'(obs[k]), 0);
        chk({tag, "_dval"}, 32'(dval_out), 0);
        chk({tag, "_border"}, 32'(border_out), 0);
        chk({tag, "_x"}, 32'(x_out), 0);
        chk({tag, "_y"}, 32'(y_out), 0);
    endtask

    // Expected window for accepted pixel (r,c) of a frame with the given offset.
    task automatic check_win(input int r, input int c, input int off);
        pixel_t obs [9];
        bit     border;
        obs    = '{t00, t01, t02, t10, t11, t12, t20, t21, t22};
        border = (r < 2) || (c < 2);
        chk($sformatf("dval_r%0dc%0d", r, c), 32'(dval_out), 1);
        chk($sformatf("border_r%0dc%0d", r, c), 32'(border_out), 32'(border));
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                exp_taps[i*3+j] = border ? 8'h00 : 8'(off + 16*(r-2+i) + (c-2+j));
                chk($sformatf("tap%0d%0d_r%0dc%0d", i, j, r, c), 32'(obs[i*3+j]), 32'(exp_taps[i*3+j]));
            end
        end
        chk($sformatf("x_r%0dc%0d", r, c), 32'(x_out), (c == 0) ? W-1 : c-1);
        chk($sformatf("y_r%0dc%0d", r, c), 32'(y_out), (r == 0) ? H-1 : r-1);
        if (!border) unmasked++;
        if (r == 2 && c == 2) begin
            for (int k = 0; k < 9; k++)
                chk($sformatf("hand22_tap%0d", k), 32'(obs[k]), 32'(8'(hand22[k] + off)));
        end
    endtask

    task automatic send(input int r, input int c, input int off, input bit sof);
        @(negedge clk);
        dval_in = 1'b1;
        sof_in  = sof;
        gray_in = 8'(off + 16*r + c);
        @(posedge clk);
        #1;
        check_win(r, c, off);
    endtask

    // Idle cycle: no new window, taps hold the last window.
    task automatic idle();
        pixel_t obs [9];
        @(negedge clk);
        dval_in = 1'b0;
        sof_in  = 1'b0;
        gray_in = $urandom_range(0, 255);
        @(posedge clk);
        #1;
        obs = '{t00, t01, t02, t10, t11, t12, t20, t21, t22};
        chk("idle_dval", 32'(dval_out), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("idle_tap%0d", k), 32'(obs[k]), 32'(exp_taps[k]));
    endtask

    task automatic frame(input int off, input bit first_sof, input bit gaps);
        unmasked = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
                end
                send(r, c, off, first_sof && r == 0 && c == 0);
            end
        end
        chk("unmasked_count", 32'(unmasked), 4);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        unmasked = 0;
        hand22   = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        for (int k = 0; k < 9; k++) exp_taps[k] = 8'h00;
        rst_n   = 1'b0;
        dval_in = 1'b0;
        sof_in  = 1'b0;
        gray_in = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame, continuous, SOF on first pixel; last window is (3,3)
        frame(0, 1'b1, 1'b0);
        chk("f1_last_centre", 32'(t11), 32'h22);
        chk("f1_last_x", 32'(x_out), 2);
        chk("f1_last_y", 32'(y_out), 2);

        // Same frame with random gaps
        frame(0, 1'b1, 1'b1);

        // Back-to-back frames, second offset by 0x80
        frame(0, 1'b1, 1'b0);
        frame(8'h80, 1'b1, 1'b0);

        // SOF at pixel (2,1): it restarts as (0,0) of a new frame
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) send(r, c, 0, r == 0 && c == 0);
        send(2, 0, 0, 1'b0);
        frame(8'h40, 1'b1, 1'b0);

        // Async reset mid-line between clock edges
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (!(r == 3 && c == 3)) send(r, c, 0, r == 0 && c == 0);
        chk("pre_reset_centre", 32'(t11), 32'h21);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        dval_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // New frame without SOF after reset
        frame(0, 1'b0, 1'b0);
        chk("post_rst_centre", 32'(t11), 32'h22);

        @(negedge clk);
        dval_in = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
